// File: rtl/des_key_sched_pkg.sv
// des_key_pkg: DES key-schedule permutation tables, rotate schedule, FSM
// encoding and round-key bank addressing constants.
package des_key_pkg;

  localparam int ROUND_W = 4;
  localparam int KIDX_W  = 2;
  localparam int BANK_AW_MAX = KIDX_W + ROUND_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    READY = 2'd2
  } state_e;

  // Table entries are 1-based bit numbers counted from the MSB (DES notation).
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1[i]];
    return o;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2[i]];
    return o;
  endfunction

  function automatic logic shift_is_two(input logic [ROUND_W-1:0] rnd);
    return SHIFTS[rnd] == 2;
  endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// Key-load handshake and round-key read port of the DES key scheduler.
interface des_key_sched_if #(
  parameter int NUM_KEYS = 1
);
  logic                    key_valid_i;
  logic                    key_ready_o;
  logic [64*NUM_KEYS-1:0]  key_i;
  logic                    encrypt_decrypt;
  logic                    keys_ready_o;
  logic                    rd_en_i;
  logic [1:0]              rd_stage_i;
  logic [3:0]              rd_round_i;
  logic                    rd_valid_o;
  logic [47:0]             rd_key_o;

  modport slave (
    input  key_valid_i, key_i, encrypt_decrypt, rd_en_i, rd_stage_i, rd_round_i,
    output key_ready_o, keys_ready_o, rd_valid_o, rd_key_o
  );

  modport master (
    output key_valid_i, key_i, encrypt_decrypt, rd_en_i, rd_stage_i, rd_round_i,
    input  key_ready_o, keys_ready_o, rd_valid_o, rd_key_o
  );
endinterface

// File: rtl/des_key_sched_round_step.sv
// One DES key-schedule round: rotate C and D left by 1 or 2, then PC-2.
module key_round_step
  import des_key_pkg::*;
(
  input  logic [55:0] cd_i,
  input  logic        shift2_i,
  output logic [55:0] cd_o,
  output logic [47:0] rk_o
);
  logic [27:0] c_in, d_in, c_rot, d_rot;

  assign c_in  = cd_i[55:28];
  assign d_in  = cd_i[27:0];
  assign c_rot = shift2_i ? {c_in[25:0], c_in[27:26]} : {c_in[26:0], c_in[27]};
  assign d_rot = shift2_i ? {d_in[25:0], d_in[27:26]} : {d_in[26:0], d_in[27]};
  assign cd_o  = {c_rot, d_rot};
  assign rk_o  = pc2_perm(cd_o);
endmodule

// File: rtl/des_key_sched.sv
// Iterative DES/3DES key scheduler: fills a 16*NUM_KEYS round-key bank and
// serves it through a registered read port with enc/dec/EDE ordering.
module des_key_sched
  import des_key_pkg::*;
#(
  parameter int NUM_KEYS         = 1,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rstn,
  des_key_sched_if.slave bus
);
  localparam int DEPTH = 16 * NUM_KEYS;
  localparam int AW    = $clog2(DEPTH);

  state_e                      state_q, state_d;
  logic [55:0]                 cd_q, cd_d;
  logic [KIDX_W-1:0]           key_idx_q, key_idx_d;
  logic [ROUND_W-1:0]          round_q, round_d;
  logic                        mode_q, mode_d;
  logic [0:3][63:0]            keys_q, keys_d;
  logic [47:0]                 bank_q [DEPTH];
  logic [47:0]                 bank_d [DEPTH];
  logic                        rd_valid_q, rd_valid_d;
  logic [47:0]                 rd_key_q, rd_key_d;

  logic [ROUNDS_PER_CYCLE:0][55:0]   cd_chain;
  logic [ROUNDS_PER_CYCLE-1:0][47:0] rk_chain;
  logic [ROUND_W:0]                  round_sum;
  logic [255:0]                      keys_in;

  assign cd_chain[0] = cd_q;

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_step
    logic [ROUND_W-1:0] step_round;
    assign step_round = round_q + ROUND_W'(j);
    key_round_step u_step (
      .cd_i     (cd_chain[j]),
      .shift2_i (shift_is_two(step_round)),
      .cd_o     (cd_chain[j+1]),
      .rk_o     (rk_chain[j])
    );
  end

  // Left-align the key bundle so keys_q[0] is always K1 whatever NUM_KEYS is.
  assign keys_in   = 256'(bus.key_i) << (64 * (4 - NUM_KEYS));
  assign round_sum = {1'b0, round_q} + 5'(ROUNDS_PER_CYCLE);

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    key_idx_d = key_idx_q;
    round_d   = round_q;
    mode_d    = mode_q;
    keys_d    = keys_q;
    bank_d    = bank_q;
    case (state_q)
      IDLE, READY: begin
        if (bus.key_valid_i) begin
          state_d   = GEN;
          keys_d    = keys_in;
          cd_d      = pc1_perm(keys_in[255:192]);
          key_idx_d = '0;
          round_d   = '0;
          mode_d    = bus.encrypt_decrypt;
        end
      end
      GEN: begin
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
          bank_d[AW'({key_idx_q, round_q + ROUND_W'(j)})] = rk_chain[j];
        round_d = round_sum[ROUND_W-1:0];
        cd_d    = cd_chain[ROUNDS_PER_CYCLE];
        if (round_sum[ROUND_W]) begin
          if (int'(key_idx_q) < NUM_KEYS - 1) begin
            key_idx_d = key_idx_q + KIDX_W'(1);
            cd_d      = pc1_perm(keys_q[key_idx_q + KIDX_W'(1)]);
          end else begin
            state_d = READY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic                stage_ok, stage_enc;
  logic [KIDX_W-1:0]   phys_idx;
  logic [ROUND_W-1:0]  phys_round;

  // In 3DES EDE the middle stage always runs opposite to the overall direction.
  always_comb begin
    stage_ok   = int'(bus.rd_stage_i) < NUM_KEYS;
    phys_idx   = mode_q ? bus.rd_stage_i : KIDX_W'(NUM_KEYS - 1) - bus.rd_stage_i;
    stage_enc  = (NUM_KEYS == 3 && bus.rd_stage_i == 2'd1) ? ~mode_q : mode_q;
    phys_round = stage_enc ? bus.rd_round_i : 4'd15 - bus.rd_round_i;
    rd_valid_d = 1'b0;
    rd_key_d   = rd_key_q;
    if (bus.rd_en_i) begin
      if (state_q == READY && stage_ok) begin
        rd_valid_d = 1'b1;
        rd_key_d   = bank_q[AW'({phys_idx, phys_round})];
      end else begin
        rd_key_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cd_q       <= '0;
      key_idx_q  <= '0;
      round_q    <= '0;
      mode_q     <= 1'b0;
      keys_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cd_q       <= cd_d;
      key_idx_q  <= key_idx_d;
      round_q    <= round_d;
      mode_q     <= mode_d;
      keys_q     <= keys_d;
      rd_valid_q <= rd_valid_d;
      rd_key_q   <= rd_key_d;
      bank_q     <= bank_d;
    end
  end

  assign bus.key_ready_o  = (state_q != GEN);
  assign bus.keys_ready_o = (state_q == READY);
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.rd_key_o     = rd_key_q;

endmodule
